// File: rtl/slice_seq_if.sv
// Handshake bundle between the slice sequencer and its environment
// (top-level start/done, slice memory read port, datapath controls, writer).
interface slice_seq_if #(
    parameter int unsigned CW = 6
) ();
    logic          start;
    logic          dir;
    logic          abort;
    logic          wr_ready;
    logic          rd_en;
    logic [CW-1:0] rd_addr;
    logic          sel;
    logic          reg_en;
    logic          wr_en;
    logic [CW-1:0] cur_idx;
    logic          busy;
    logic          done;

    modport master (
        input  start, dir, abort, wr_ready,
        output rd_en, rd_addr, sel, reg_en, wr_en, cur_idx, busy, done
    );

    modport slave (
        output start, dir, abort, wr_ready,
        input  rd_en, rd_addr, sel, reg_en, wr_en, cur_idx, busy, done
    );
endinterface

// File: rtl/slice_seq_ctrl.sv
// Sequencer for the slice encoder datapath: per slice index it reads memory,
// latches the slice, recirculates it PASSES times and hands it to the writer.
module slice_seq_ctrl #(
    parameter int unsigned SLICES = 64,
    parameter int unsigned CW     = 6,
    parameter int unsigned PASSES = 1
) (
    input  logic        clk,
    input  logic        rst,
    slice_seq_if.master bus
);
    localparam int unsigned PW = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_LATCH   = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [CW-1:0] IDX_LAST  = CW'(SLICES - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [PW-1:0] pass_q, pass_d;
    logic          dir_q, dir_d;
    logic          at_term;

    logic rd_en_q, rd_en_d;
    logic sel_q, sel_d;
    logic reg_en_q, reg_en_d;
    logic wr_en_q, wr_en_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // Terminal index depends on the direction captured at start.
    always_comb begin
        at_term = dir_q ? (idx_q == IDX_LAST) : (idx_q == '0);
    end

    // Next-state and next-output logic; abort outranks any WRITE transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        dir_d   = dir_q;

        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        dir_d   = bus.dir;
                        idx_d   = bus.dir ? '0 : IDX_LAST;
                        pass_d  = '0;
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    state_d = S_LATCH;
                end
                S_LATCH: begin
                    pass_d  = PW'(1);
                    state_d = (PASSES == 1) ? S_WRITE : S_COMPUTE;
                end
                S_COMPUTE: begin
                    pass_d = pass_q + PW'(1);
                    if (pass_q == PASS_LAST) begin
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.wr_ready) begin
                        if (at_term) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = dir_q ? (idx_q + CW'(1)) : (idx_q - CW'(1));
                            state_d = S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        rd_en_d  = (state_d == S_READ);
        sel_d    = (state_d == S_COMPUTE);
        reg_en_d = (state_d == S_LATCH) || (state_d == S_COMPUTE);
        wr_en_d  = (state_d == S_WRITE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            pass_q   <= '0;
            dir_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            sel_q    <= 1'b0;
            reg_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pass_q   <= pass_d;
            dir_q    <= dir_d;
            rd_en_q  <= rd_en_d;
            sel_q    <= sel_d;
            reg_en_q <= reg_en_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = idx_q;
    assign bus.sel     = sel_q;
    assign bus.reg_en  = reg_en_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.cur_idx = idx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_slice_seq_ctrl.sv
// Bench for slice_seq_ctrl: two instances (PASSES=1 and PASSES=3) share stimulus
// and are checked every cycle against a slice/phase reference model.
module tb_slice_seq_ctrl;
    localparam int unsigned SLICES = 64;
    localparam int unsigned CW     = 6;
    localparam int unsigned OW     = 6 + 2 * CW;
    localparam int OB_RD   = 2 * CW + 5;
    localparam int OB_SEL  = 2 * CW + 4;
    localparam int OB_REG  = 2 * CW + 3;
    localparam int OB_WR   = 2 * CW + 2;
    localparam int OB_BUSY = 2 * CW + 1;
    localparam int OB_DONE = 2 * CW;

    typedef logic [OW-1:0] obs_t;

    typedef struct {
        logic start;
        logic dir;
        logic abort;
        logic wr_ready;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start, dir, abort, wr_ready;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    slice_seq_if #(.CW(CW)) bus0 ();
    slice_seq_if #(.CW(CW)) bus1 ();

    assign bus0.start = start;  assign bus1.start = start;
    assign bus0.dir = dir;      assign bus1.dir = dir;
    assign bus0.abort = abort;  assign bus1.abort = abort;
    assign bus0.wr_ready = wr_ready;
    assign bus1.wr_ready = wr_ready;

    slice_seq_ctrl #(.SLICES(SLICES), .CW(CW), .PASSES(1)) u_p1 (.clk(clk), .rst(rst), .bus(bus0));
    slice_seq_ctrl #(.SLICES(SLICES), .CW(CW), .PASSES(3)) u_p3 (.clk(clk), .rst(rst), .bus(bus1));

    // Reference: a job is SLICES slices in order; each slice is phase 0 (read),
    // phases 1..P (encoder passes, first from memory), phase P+1 (write, waits).
    bit m_act[2];
    bit m_done[2];
    bit m_dir[2];
    int m_n[2];
    int m_ph[2];
    int m_idx[2];

    function automatic int passes_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic obs_t obs(int d);
        if (d == 0)
            return {bus0.rd_en, bus0.sel, bus0.reg_en, bus0.wr_en, bus0.busy, bus0.done,
                    bus0.rd_addr, bus0.cur_idx};
        return {bus1.rd_en, bus1.sel, bus1.reg_en, bus1.wr_en, bus1.busy, bus1.done,
                bus1.rd_addr, bus1.cur_idx};
    endfunction

    function automatic obs_t mk(bit rd, bit sl, bit rg, bit wr, bit by, bit dn, int ix);
        return {rd, sl, rg, wr, by, dn, CW'(ix), CW'(ix)};
    endfunction

    function automatic obs_t model_exp(int d);
        int p = passes_of(d);
        int ph = m_ph[d];
        if (m_done[d]) return mk(0, 0, 0, 0, 1, 1, m_idx[d]);
        if (m_act[d])
            return mk(ph == 0, (ph >= 2) && (ph <= p), (ph >= 1) && (ph <= p), ph == p + 1,
                      1, 0, m_idx[d]);
        return mk(0, 0, 0, 0, 0, 0, m_idx[d]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_done[d] = 0; m_dir[d] = 0;
            m_n[d] = 0; m_ph[d] = 0; m_idx[d] = 0;
        end
    endtask

    task automatic model_step(int d);
        int p = passes_of(d);
        if (m_done[d]) begin
            m_done[d] = 0;
        end else if (m_act[d]) begin
            if (abort) m_act[d] = 0;
            else if (m_ph[d] < p + 1) m_ph[d]++;
            else if (wr_ready) begin
                if (m_n[d] == SLICES - 1) begin
                    m_act[d] = 0;
                    m_done[d] = 1;
                end else begin
                    m_n[d]++;
                    m_ph[d] = 0;
                end
            end
        end else if (start) begin
            m_act[d] = 1; m_dir[d] = dir; m_n[d] = 0; m_ph[d] = 0;
        end
        if (m_act[d]) m_idx[d] = m_dir[d] ? m_n[d] : (SLICES - 1 - m_n[d]);
    endtask

    task automatic chk_obs(string name, obs_t got, obs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(bit s, bit d, bit a, bit w);
        start = s; dir = d; abort = a; wr_ready = w;
    endtask

    // One clock: DUTs and model advance on the edge, compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_step(d);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk_obs($sformatf("model_p%0d", passes_of(d)), obs(d), model_exp(d));
    endtask

    vec_t tbl[12];
    obs_t o;
    int   found;
    int   done_at[2], done_n[2], rd_n[2], wr_n[2];

    task automatic set_row(int i, bit s, bit d, bit a, bit w, obs_t e);
        tbl[i].start = s; tbl[i].dir = d; tbl[i].abort = a; tbl[i].wr_ready = w; tbl[i].exp = e;
    endtask

    initial begin
        set_row(0,  1, 0, 0, 1, mk(1, 0, 0, 0, 1, 0, 63));
        set_row(1,  0, 0, 0, 1, mk(0, 0, 1, 0, 1, 0, 63));
        set_row(2,  0, 0, 0, 0, mk(0, 0, 0, 1, 1, 0, 63));
        set_row(3,  0, 0, 0, 0, mk(0, 0, 0, 1, 1, 0, 63));
        set_row(4,  0, 0, 0, 1, mk(1, 0, 0, 0, 1, 0, 62));
        set_row(5,  0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 62));
        set_row(6,  0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 62));
        set_row(7,  1, 1, 0, 1, mk(1, 0, 0, 0, 1, 0, 0));
        set_row(8,  0, 1, 0, 1, mk(0, 0, 1, 0, 1, 0, 0));
        set_row(9,  1, 1, 0, 1, mk(0, 0, 0, 1, 1, 0, 0));
        set_row(10, 0, 1, 0, 1, mk(1, 0, 0, 0, 1, 0, 1));
        set_row(11, 0, 1, 1, 1, mk(0, 0, 0, 0, 0, 0, 1));

        rst = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_obs("reset_p1", obs(0), '0);
        chk_obs("reset_p3", obs(1), '0);
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].start, tbl[i].dir, tbl[i].abort, tbl[i].wr_ready);
            cycle();
            chk_obs($sformatf("table_row%0d", i), obs(0), tbl[i].exp);
        end

        // Full jobs with wr_ready high, both directions.
        for (int dv = 1; dv >= 0; dv--) begin
            for (int d = 0; d < 2; d++) begin
                done_at[d] = 0; done_n[d] = 0; rd_n[d] = 0; wr_n[d] = 0;
            end
            drive(1, dv[0], 0, 1);
            for (int k = 1; k <= 330; k++) begin
                cycle();
                drive(0, dv[0], 0, 1);
                for (int d = 0; d < 2; d++) begin
                    o = obs(d);
                    if (o[OB_DONE]) begin
                        done_n[d]++;
                        if (done_at[d] == 0) done_at[d] = k;
                    end
                    if (o[OB_RD]) rd_n[d]++;
                    if (o[OB_WR]) wr_n[d]++;
                end
            end
            chk1($sformatf("done_cycle_p1_dir%0d", dv), done_at[0], 193);
            chk1($sformatf("done_cycle_p3_dir%0d", dv), done_at[1], 321);
            chk1($sformatf("done_pulses_p1_dir%0d", dv), done_n[0], 1);
            chk1($sformatf("done_pulses_p3_dir%0d", dv), done_n[1], 1);
            chk1($sformatf("reads_p1_dir%0d", dv), rd_n[0], 64);
            chk1($sformatf("reads_p3_dir%0d", dv), rd_n[1], 64);
            chk1($sformatf("writes_p1_dir%0d", dv), wr_n[0], 64);
            chk1($sformatf("writes_p3_dir%0d", dv), wr_n[1], 64);
        end

        // Writer stall on slice 5.
        drive(1, 1, 0, 1);
        cycle();
        drive(0, 1, 0, 1);
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            cycle();
            if (bus0.wr_en && bus0.cur_idx == CW'(5)) found = 1;
        end
        chk1("stall_reach_slice5", found, 1);
        drive(0, 1, 0, 0);
        repeat (10) begin
            cycle();
            o = obs(0);
            chk1("stall_hold", int'({o[OB_RD], o[OB_WR], o[CW-1:0]}), int'({1'b0, 1'b1, 6'd5}));
        end
        drive(0, 1, 0, 1);
        cycle();
        chk1("stall_next_read", int'({bus0.rd_en, bus0.rd_addr}), int'({1'b1, 6'd6}));
        drive(0, 1, 1, 1);
        cycle();
        drive(0, 1, 0, 1);
        cycle();

        // start while busy and start coincident with done are both dropped.
        drive(1, 1, 0, 1);
        cycle();
        found = 0;
        for (int k = 1; k < 400 && found == 0; k++) begin
            drive((k % 7) == 0, 1, 0, 1);
            cycle();
            if (bus0.done) found = 1;
        end
        chk1("ignore_reach_done", found, 1);
        drive(1, 1, 0, 1);
        cycle();
        chk1("start_on_done_ignored", int'({bus0.busy, bus0.done}), 0);
        drive(0, 1, 0, 1);
        repeat (3) begin
            cycle();
            chk1("stay_idle_after_done", int'(bus0.busy), 0);
        end
        for (int k = 0; k < 400 && (m_act[1] || m_done[1]); k++) cycle();
        chk1("p3_back_to_idle", int'(bus1.busy), 0);

        // Abort in WRITE on slice 10 beats the concurrent transfer.
        drive(1, 1, 0, 1);
        cycle();
        drive(0, 1, 0, 1);
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            cycle();
            if (bus0.wr_en && bus0.cur_idx == CW'(10)) found = 1;
        end
        chk1("abort_reach_slice10", found, 1);
        drive(0, 1, 1, 1);
        cycle();
        chk1("abort_to_idle", int'({bus0.busy, bus0.wr_en, bus0.done}), 0);
        drive(0, 1, 0, 1);
        repeat (20) cycle();
        drive(1, 1, 0, 1);
        cycle();
        chk1("restart_at_zero", int'({bus0.rd_en, bus0.rd_addr}), int'({1'b1, 6'd0}));
        drive(0, 1, 1, 1);
        cycle();

        // Asynchronous reset mid-COMPUTE.
        drive(1, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 1);
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            cycle();
            if (bus1.sel) found = 1;
        end
        chk1("reach_compute", found, 1);
        #2 rst = 1'b1;
        #1;
        chk_obs("async_reset_p1", obs(0), '0);
        chk_obs("async_reset_p3", obs(1), '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 1);
        repeat (5) cycle();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom % 8) == 0, 1'($urandom % 2), ($urandom % 50) == 0, ($urandom % 4) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
